rr_arbiter4way16: RTL and testbench
===================================

# rr_arbiter4way16

Round-robin packet arbiter that shares one 16-bit output channel among four requesters. It owns the select input of a `mux4way16` instance and sequences which source drives it. Grants are locked for a whole packet, and each beat is registered into a single-entry output stage with valid/ready handshakes on both sides. It sits between the four producer ports and the single downstream consumer of the shared bus.

## Interface
- `MAX_BEATS`, default 16: maximum beats per grant before forced release. Legal range 1..256.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  4  per-requester beat valid; bit i belongs to requester i.
- `in_last`  input  4  per-requester end-of-packet flag, qualified by `in_valid[i]`.
- `in_data0`..`in_data3`  input  16 each  requester payloads, routed through `mux4way16` (d0..d3).
- `in_ready`  output  4  per-requester beat accepted; at most one bit high in any cycle.
- `out_valid`  output  1  output register holds a beat.
- `out_data`  output  16  registered beat payload.
- `out_last`  output  1  registered copy of the source's `in_last` for that beat.
- `out_src`  output  2  index of the requester that supplied the beat.
- `out_ready`  input  1  consumer accepts the output beat.
- `sel`  output  2  current grant; drives the `mux4way16` select.
- `busy`  output  1  high while the arbiter is in LOCK.

## Operation
- The arbiter has two states, IDLE and LOCK. It holds a round-robin pointer `ptr` (2 bits) and a beat counter `cnt`.
- **IDLE:**
  - If `in_valid` is nonzero, search the requesters in order `ptr+1, ptr+2, ptr+3, ptr` (mod 4).
  - Register the first requester found with valid high into `sel`, clear `cnt` to 0, and go to LOCK.
  - `in_ready` is 0 throughout IDLE.
- **LOCK:**
  - `in_ready[sel] = in_valid[sel]`-independent `accept`, where `accept = !out_valid || out_ready`. All other `in_ready` bits are 0.
  - A transfer occurs when `in_valid[sel] && in_ready[sel]`. On a transfer:
    - `out_data` ← mux output.
    - `out_last` ← `in_last[sel]`.
    - `out_src` ← `sel`.
    - `out_valid` ← 1.
    - `cnt` ← `cnt + 1`.
  - **Release:** on a transfer where `in_last[sel]` is 1, or where `cnt+1 == MAX_BEATS`.
    - Next state is IDLE and `ptr` ← `sel`.
    - A forced release does not modify `out_last`.
  - If the granted requester drops `in_valid`, the grant is held indefinitely. There is no timeout on a stalled packet.
- **Output register:**
  - `out_valid` clears when `out_ready && out_valid` and no new transfer happens in the same cycle.
  - A simultaneous drain and fill keeps `out_valid` at 1 with the new beat.
  - While `out_valid && !out_ready`, `out_data`, `out_last` and `out_src` stay stable.
- `cnt` width is `$clog2(MAX_BEATS+1)`. With `MAX_BEATS=1`, every grant lasts exactly one beat.
- Requests arriving while in LOCK never preempt the current grant. They are served in round-robin order from the released index.

## Timing
- **Reset values (asynchronous, while `rst_n`=0):**
  - state IDLE, `ptr`=3 (requester 0 has first priority), `sel`=0, `cnt`=0.
  - `out_valid`=0, `out_data`=0, `out_last`=0, `out_src`=0.
  - `in_ready`=0, `busy`=0.
- **Arbitration latency:** one cycle. `in_valid` seen high in IDLE at edge N gives LOCK and `in_ready` high during cycle N+1. The first beat is in the output register after edge N+1.
- **Throughput:**
  - One beat per cycle inside a packet while `out_ready` stays high.
  - Exactly one IDLE bubble cycle between consecutive grants.
- `in_ready` is combinational from state, `sel`, `out_valid` and `out_ready`. It has no combinational path from `in_valid`.
- **Reset mid-packet:** everything returns to reset values immediately and any beat held in the output register is dropped. After reset release, arbitration restarts from requester 0.
- `sel` changes only on the IDLE→LOCK edge, so the mux select is glitch-free during a packet.

## Test plan
- **Reset:** assert `rst_n`=0 mid-packet with `out_valid`=1 → all outputs 0 asynchronously. After release, `in_valid`=4'b1111 grants requester 0 first.
- **Single requester:** requester 2 sends a 3-beat packet 0x1111, 0x2222, 0x3333 (last on the third beat) with `out_ready`=1. → `in_ready[2]` is high 3 cycles, starting one cycle after the request. `out_data` shows the three values on consecutive cycles with `out_src`=2 and `out_last` only on 0x3333. `busy` then falls.
- **Round-robin fairness:** all four requesters keep sending 1-beat packets continuously. → Grant order is 0,1,2,3,0,1…, with one idle cycle between grants and no requester granted twice before the others.
- **Backpressure:** hold `out_ready`=0 for 5 cycles mid-packet from requester 1. → `in_ready` stays 0 after the register fills, and `out_data` holds stable. When `out_ready` rises, drain and fill happen in the same cycle and no beats are lost or duplicated.
- **Forced release:** `MAX_BEATS`=4, requester 3 streams 10 beats with no `in_last`, and requester 0 is also requesting. → After 4 beats the grant goes to requester 0. `out_last` stays 0 on beat 4.
- **Stalled grant:** requester 1 is granted, then drops `in_valid` for 20 cycles while requester 2 requests. → `sel` stays 1, `busy` stays high, `in_ready[2]`=0, and the packet resumes when requester 1 reasserts `in_valid`.

Source files
------------

// File: rtl/rr_arbiter4way16.sv
// Round-robin packet arbiter sharing one 16-bit channel among four requesters.
// A grant is locked for a whole packet, or until MAX_BEATS beats have moved.
// Each beat passes through a single-entry output register with valid/ready
// handshakes on both sides.

module mux4way16 (
    input  logic [15:0] d0,
    input  logic [15:0] d1,
    input  logic [15:0] d2,
    input  logic [15:0] d3,
    input  logic [1:0]  s,
    output logic [15:0] y
);

    // Select one of four 16-bit sources.
    always_comb begin
        case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = 16'h0000;
        endcase
    end

endmodule

module rr_arbiter4way16 #(
    parameter int MAX_BEATS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  in_valid,
    input  logic [3:0]  in_last,
    input  logic [15:0] in_data0,
    input  logic [15:0] in_data1,
    input  logic [15:0] in_data2,
    input  logic [15:0] in_data3,
    output logic [3:0]  in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic [1:0]  out_src,
    input  logic        out_ready,
    output logic [1:0]  sel,
    output logic        busy
);

    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_BEATS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t         state_r;
    logic [1:0]     ptr_r;
    logic [1:0]     sel_r;
    logic [CW-1:0]  cnt_r;
    logic           busy_r;
    logic           out_valid_r;
    logic [15:0]    out_data_r;
    logic           out_last_r;
    logic [1:0]     out_src_r;

    logic [15:0]    mux_y_s;
    logic [1:0]     grant_s;
    logic           accept_s;
    logic           xfer_s;
    logic           release_s;
    logic [CW-1:0]  cnt_inc_s;

    // First requester with valid high, searching ptr+1, ptr+2, ptr+3, ptr.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] req);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + k[1:0];
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    mux4way16 u_mux (
        .d0 (in_data0),
        .d1 (in_data1),
        .d2 (in_data2),
        .d3 (in_data3),
        .s  (sel_r),
        .y  (mux_y_s)
    );

    assign grant_s   = rr_pick(ptr_r, in_valid);
    assign accept_s  = !out_valid_r || out_ready;
    assign xfer_s    = (state_r == ST_LOCK) && accept_s && in_valid[sel_r];
    assign cnt_inc_s = cnt_r + CW'(1);
    assign release_s = xfer_s && (in_last[sel_r] || (cnt_inc_s == MAX_C));

    // Ready goes only to the granted requester, and only when the output slot can take a beat.
    always_comb begin
        in_ready = 4'b0000;
        if ((state_r == ST_LOCK) && accept_s) begin
            in_ready[sel_r] = 1'b1;
        end else begin
            in_ready = 4'b0000;
        end
    end

    // Grant FSM: pick a requester in IDLE, hold it through the packet in LOCK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= 2'd3;
            sel_r   <= 2'd0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|in_valid) begin
                        sel_r   <= grant_s;
                        cnt_r   <= '0;
                        state_r <= ST_LOCK;
                        busy_r  <= 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (xfer_s) begin
                        cnt_r <= cnt_inc_s;
                        if (release_s) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            ptr_r   <= sel_r;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output stage: fill on transfer, drain on consumer ready; both may happen together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 16'h0000;
            out_last_r  <= 1'b0;
            out_src_r   <= 2'd0;
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= mux_y_s;
            out_last_r  <= in_last[sel_r];
            out_src_r   <= sel_r;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign out_src   = out_src_r;
    assign sel       = sel_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_rr_arbiter4way16.sv
// Randomized bench for rr_arbiter4way16 against a packet-level reference model.

module tb_rr_arbiter4way16;

    localparam int MAXB = 16;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [15:0] tb_data [4];
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic [1:0]  out_src;
    logic        out_ready;
    logic [1:0]  sel;
    logic        busy;

    int checks;
    int failures;

    // Reference model: who owns the channel, beats moved in this grant,
    // last requester served, and contents of the one-beat output slot.
    bit          m_lock;
    int          m_owner;
    int          m_beats;
    int          m_rr;
    bit          m_full;
    logic [15:0] m_data;
    logic        m_last;
    int          m_src;

    rr_arbiter4way16 #(.MAX_BEATS(MAXB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data0  (tb_data[0]),
        .in_data1  (tb_data[1]),
        .in_data2  (tb_data[2]),
        .in_data3  (tb_data[3]),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lock  = 1'b0;
        m_owner = 0;
        m_beats = 0;
        m_rr    = 3;
        m_full  = 1'b0;
        m_data  = 16'h0000;
        m_last  = 1'b0;
        m_src   = 0;
    endtask

    task automatic check_outputs();
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0000;
        if (m_lock && (!m_full || out_ready)) exp_rdy[m_owner] = 1'b1;
        check_value("in_ready",  32'(in_ready),  32'(exp_rdy));
        check_value("busy",      32'(busy),      32'(m_lock));
        check_value("sel",       32'(sel),       32'(m_owner));
        check_value("out_valid", 32'(out_valid), 32'(m_full));
        check_value("out_data",  32'(out_data),  32'(m_data));
        check_value("out_last",  32'(out_last),  32'(m_last));
        check_value("out_src",   32'(out_src),   32'(m_src));
    endtask

    task automatic check_all_zero();
        check_value("rst_in_ready",  32'(in_ready),  32'd0);
        check_value("rst_busy",      32'(busy),      32'd0);
        check_value("rst_sel",       32'(sel),       32'd0);
        check_value("rst_out_valid", 32'(out_valid), 32'd0);
        check_value("rst_out_data",  32'(out_data),  32'd0);
        check_value("rst_out_last",  32'(out_last),  32'd0);
        check_value("rst_out_src",   32'(out_src),   32'd0);
    endtask

    // One clock of the arbiter rules, evaluated on the inputs presented this cycle.
    task automatic model_step();
        bit accept;
        bit found;
        int idx;
        accept = !m_full || out_ready;
        if (!m_lock) begin
            if (m_full && out_ready) m_full = 1'b0;
            if (in_valid != 4'b0000) begin
                found = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    idx = (m_rr + k) % 4;
                    if (!found && in_valid[idx]) begin
                        m_owner = idx;
                        found   = 1'b1;
                    end
                end
                m_beats = 0;
                m_lock  = 1'b1;
            end
        end else begin
            if (m_full && out_ready) m_full = 1'b0;
            if (accept && in_valid[m_owner]) begin
                m_full = 1'b1;
                m_data = tb_data[m_owner];
                m_last = in_last[m_owner];
                m_src  = m_owner;
                m_beats++;
                if (in_last[m_owner] || m_beats == MAXB) begin
                    m_lock = 1'b0;
                    m_rr   = m_owner;
                end
            end
        end
    endtask

    // Random inputs, biased per test phase.
    task automatic drive_inputs(input int cyc, input bit all_valid);
        int pv;
        int pl;
        int pr;
        if (cyc < 500) begin
            pv = 50; pl = 30; pr = 80;
        end else if (cyc < 900) begin
            pv = 100; pl = 100; pr = 100;
        end else if (cyc < 1400) begin
            pv = 90; pl = 2; pr = 70;
        end else begin
            pv = 70; pl = 20; pr = ((cyc % 16) < 6) ? 0 : 100;
        end
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = all_valid ? 1'b1 : ($urandom_range(99) < pv);
            in_last[i]  = ($urandom_range(99) < pl);
            tb_data[i]  = 16'($urandom);
        end
        out_ready = ($urandom_range(99) < pr);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        in_last   = 4'b0000;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) tb_data[i] = 16'h0000;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            bit after_rst;
            after_rst = 1'b0;
            @(negedge clk);
            if (cyc == 333 || cyc == 1234) begin
                // Asynchronous reset in the middle of traffic.
                rst_n = 1'b0;
                #1;
                check_all_zero();
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
                after_rst = 1'b1;
            end
            check_outputs();
            drive_inputs(cyc, after_rst);
            @(posedge clk);
            model_step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
